fetch_unit: RTL and testbench

- Instruction fetch front-end for the superscalar core.
- Holds the PC and acts as AXI-style read master toward the instruction memory slave: one single-beat read per instruction.
- Returned words go into a small instruction buffer consumed by decode via a valid/ready handshake.
- Accepts redirects (branch/jump/exception) that flush the buffer and discard any in-flight response.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/inst_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end: AXI read constants and FSM encoding.
package fetch_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [7:0] LEN_SINGLE  = 8'd0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// AXI-style single-beat read channel between the fetch unit and instruction memory.
interface fetch_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             arvalid;
    logic [WIDTH-1:0] araddr;
    logic [1:0]       arburst;
    logic [2:0]       arsize;
    logic [7:0]       arlen;
    logic             arready;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             rlast;
    logic [1:0]       rresp;
    logic             rready;

    modport master (
        output arvalid, araddr, arburst, arsize, arlen, rready,
        input  arready, rvalid, rdata, rlast, rresp
    );

    modport slave (
        input  arvalid, araddr, arburst, arsize, arlen, rready,
        output arready, rvalid, rdata, rlast, rresp
    );
endinterface

// File: rtl/inst_fifo.sv
// Registered instruction buffer with flush; flush takes priority over push and pop.
module inst_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    assign do_pop = pop && (cnt_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !do_pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!push && do_pop) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Storage is reset so the head fields read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count      = cnt_q;
    assign head_valid = (cnt_q != '0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC, single-outstanding AXI read master and decode-facing buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      BUF_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_unit_if.master     axi,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_err,
    input  logic             inst_ready
);
    localparam int unsigned ENTRY_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic [WIDTH-1:0] araddr_q, araddr_d;
    logic             drop_q, drop_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             ar_hs, r_hs, push;
    logic [CNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0] head_data;

    assign ar_hs = arvalid_q && axi.arready;
    assign r_hs  = rready_q && axi.rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect seen in IDLE holds off issue for one cycle so the new PC is used.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!redirect_valid && (fifo_count < CNT_W'(BUF_DEPTH))) state_d = ST_ADDR;
            ST_ADDR: if (ar_hs) state_d = ST_DATA;
            ST_DATA: if (r_hs)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arvalid_d = (state_d == ST_ADDR);
        rready_d  = (state_d == ST_DATA);
        araddr_d  = araddr_q;
        req_pc_d  = req_pc_q;
        if ((state_q == ST_IDLE) && (state_d == ST_ADDR)) begin
            araddr_d = WIDTH'(pc_q >> 2);
            req_pc_d = pc_q;
        end
    end

    // A beat completing on the redirect edge is flushed anyway, so it does not arm drop.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        push   = 1'b0;
        if (r_hs) begin
            if (drop_q) begin
                drop_d = 1'b0;
            end else begin
                push = 1'b1;
                pc_d = req_pc_q + WIDTH'(4);
            end
        end
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if ((state_q == ST_ADDR) || ((state_q == ST_DATA) && !r_hs)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            araddr_q  <= '0;
            drop_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            araddr_q  <= araddr_d;
            drop_q    <= drop_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_inst_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  ({axi.rresp != RESP_OKAY, req_pc_q, axi.rdata}),
        .pop        (inst_ready),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head_valid (inst_valid),
        .head_data  (head_data)
    );

    assign inst_data = head_data[WIDTH-1:0];
    assign inst_pc   = head_data[2*WIDTH-1:WIDTH];
    assign inst_err  = head_data[2*WIDTH];

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arburst = BURST_FIXED;
    assign axi.arsize  = SIZE_WORD;
    assign axi.arlen   = LEN_SINGLE;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: AXI memory slave, decode consumer and an instruction-stream model.
module tb_fetch_unit;
    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          inst_valid;
    logic [W-1:0]  inst_data;
    logic [W-1:0]  inst_pc;
    logic          inst_err;
    logic          inst_ready;

    fetch_unit_if #(.WIDTH(W)) axi ();

    fetch_unit #(
        .WIDTH     (W),
        .BUF_DEPTH (D),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axi            (axi),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: next PC decode should see, entries the buffer should hold, and the slave's pending beat.
    logic [31:0] model_pc;
    int          occ;
    bit          pend, pend_stale, ar_stale;
    logic [31:0] pend_addr;
    int unsigned pend_wait;
    bit          ar_hold;
    logic [31:0] ar_prev;
    bit          exp_ar;
    logic [31:0] exp_addr;
    int unsigned r_cnt;

    int unsigned ar_prob, rdy_prob, lat_max, redir_pm;
    bit          force_redir;
    logic [31:0] force_pc;
    bit          want_combo, combo_done, want_dr, dr_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'h0000_0013 + idx;
    endfunction

    function automatic bit err_at(input logic [31:0] idx);
        return (idx % 7) == 2;
    endfunction

    function automatic logic [31:0] pick_pc();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2);
        return 32'($urandom_range(255)) << 2;
    endfunction

    task automatic model_reset();
        model_pc = 32'h0; occ = 0; r_cnt = 0;
        pend = 0; pend_stale = 0; ar_stale = 0; pend_wait = 0; pend_addr = '0;
        ar_hold = 0; ar_prev = '0; exp_ar = 1; exp_addr = 32'h0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b1;
        redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_eq("inst_valid", 32'(inst_valid), 32'(occ != 0));

        if (pend && pend_wait == 0) begin
            axi.rvalid = 1'b1;
            axi.rdata  = mem_word(pend_addr);
            axi.rresp  = err_at(pend_addr) ? 2'b10 : 2'b00;
        end else begin
            axi.rvalid = 1'b0;
            axi.rdata  = $urandom;
            axi.rresp  = 2'b00;
        end
        axi.arready    = ($urandom_range(99) < ar_prob);
        inst_ready     = ($urandom_range(99) < rdy_prob);
        redirect_valid = ($urandom_range(999) < redir_pm);
        redirect_pc    = pick_pc();
        if (force_redir) begin
            redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 0;
        end
        if (want_combo && occ == 3 && axi.rvalid && axi.rready && !pend_stale) begin
            inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
            want_combo = 0; combo_done = 1;
        end
        if (want_dr && axi.rready && !axi.rvalid) begin
            redirect_valid = 1'b1; redirect_pc = 32'h40;
            want_dr = 0; dr_done = 1;
        end

        // Effects of the coming rising edge.
        if (axi.rvalid && axi.rready) begin
            if (!pend_stale) occ++;
            pend = 0; r_cnt++;
        end else if (pend && pend_wait > 0) begin
            pend_wait--;
        end
        if (axi.arvalid && ar_hold) check_eq("araddr_stable", axi.araddr, ar_prev);
        if (axi.arvalid && axi.arready) begin
            check_eq("ar_single", 32'(pend), 32'h0);
            check_eq("arburst", 32'(axi.arburst), 32'h0);
            check_eq("arsize", 32'(axi.arsize), 32'h2);
            check_eq("arlen", 32'(axi.arlen), 32'h0);
            if (exp_ar) begin
                check_eq("araddr_target", axi.araddr, exp_addr);
                exp_ar = 0;
            end
            pend = 1; pend_stale = ar_stale; ar_stale = 0;
            pend_addr = axi.araddr; pend_wait = $urandom_range(lat_max);
            ar_hold = 0;
        end else begin
            ar_hold = axi.arvalid; ar_prev = axi.araddr;
        end
        if (inst_valid && inst_ready) begin
            check_eq("inst_pc", inst_pc, model_pc);
            check_eq("inst_data", inst_data, mem_word(model_pc >> 2));
            check_eq("inst_err", 32'(inst_err), 32'(err_at(model_pc >> 2)));
            model_pc = model_pc + 32'h4;
            occ--;
        end
        if (redirect_valid) begin
            if (pend) pend_stale = 1;
            if (axi.arvalid && !axi.arready) ar_stale = 1;
            exp_ar   = !(axi.arvalid && !axi.arready);
            exp_addr = redirect_pc >> 2;
            model_pc = redirect_pc;
            occ      = 0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_arvalid"}, 32'(axi.arvalid), 32'h0);
        check_eq({tag, "_araddr"}, axi.araddr, 32'h0);
        check_eq({tag, "_rready"}, 32'(axi.rready), 32'h0);
        check_eq({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
        check_eq({tag, "_inst_data"}, inst_data, 32'h0);
        check_eq({tag, "_inst_pc"}, inst_pc, 32'h0);
        check_eq({tag, "_inst_err"}, 32'(inst_err), 32'h0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq({tag, "_arvalid"}, 32'(axi.arvalid), 32'h1);
        check_eq({tag, "_araddr"}, axi.araddr, 32'h0);
    endtask

    initial begin
        force_redir = 0; want_combo = 0; combo_done = 0; want_dr = 0; dr_done = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        release_reset("first_ar");

        // Decode stalled: buffer fills to depth and issue stops.
        ar_prob = 100; rdy_prob = 0; lat_max = 0; redir_pm = 0;
        repeat (20) cycle();
        check_eq("stall_beats", r_cnt, 32'(D));
        check_eq("stall_arvalid", 32'(axi.arvalid), 32'h0);
        check_eq("stall_occ", 32'(inst_valid), 32'h1);

        // Drain and stream, including the error response at pc 8.
        rdy_prob = 100;
        repeat (40) cycle();

        // Redirect on an edge that pushes and pops with three entries buffered.
        rdy_prob = 0; force_redir = 1; force_pc = 32'h0; want_combo = 1;
        for (int k = 0; k < 200 && !combo_done; k++) cycle();
        check_eq("combo_reached", 32'(combo_done), 32'h1);
        want_combo = 0;
        rdy_prob = 100;
        repeat (20) cycle();

        // Redirect while waiting in the data phase with a slow slave.
        lat_max = 3;
        want_dr = 1;
        for (int k = 0; k < 200 && !dr_done; k++) cycle();
        check_eq("dr_reached", 32'(dr_done), 32'h1);
        want_dr = 0;
        repeat (30) cycle();

        // Randomized traffic with redirects, backpressure and PC wrap.
        ar_prob = 70; rdy_prob = 60; lat_max = 3; redir_pm = 30;
        repeat (3000) cycle();

        // Reset asserted in the middle of a data phase.
        begin
            bit hit = 0;
            for (int k = 0; k < 200 && !hit; k++) begin
                cycle();
                hit = axi.rready;
            end
            check_eq("mid_data_reached", 32'(hit), 32'h1);
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        model_reset();
        repeat (2) @(negedge clk);
        release_reset("rerun_ar");
        ar_prob = 100; rdy_prob = 100; lat_max = 0; redir_pm = 0;
        repeat (30) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
